// File: rtl/conv_window_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | conv_window_buffer                                                         |
// | K x K sliding-window generator over a raster pixel stream, runtime W/H.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module conv_window_buffer #(
   parameter int DATA_WIDTH    = 8,
   parameter int KERNEL        = 3,
   parameter int MAX_IMG_WIDTH = 224,
   parameter int DIM_BITS      = 8
) (
   input  logic                                 clk,
   input  logic                                 resetn,
   input  logic                                 clear,
   input  logic [DIM_BITS-1:0]                  img_width,
   input  logic [DIM_BITS-1:0]                  img_height,
   input  logic                                 in_valid,
   input  logic [DATA_WIDTH-1:0]                in_data,
   output logic                                 win_valid,
   output logic [KERNEL*KERNEL*DATA_WIDTH-1:0]  win_data,
   output logic                                 frame_done
);

   localparam logic [DIM_BITS-1:0] c_max_w = DIM_BITS'(MAX_IMG_WIDTH);
   localparam logic [DIM_BITS-1:0] c_km1   = DIM_BITS'(KERNEL - 1);
   localparam logic [DIM_BITS-1:0] c_one   = DIM_BITS'(1);

   logic [DIM_BITS-1:0]   r_col;
   logic [DIM_BITS-1:0]   r_row;
   logic [DIM_BITS-1:0]   r_w;
   logic [DIM_BITS-1:0]   r_h;
   logic                  r_win_valid;
   logic                  r_frame_done;
   logic [DATA_WIDTH-1:0] r_line [KERNEL-1][MAX_IMG_WIDTH];
   logic [DATA_WIDTH-1:0] r_win  [KERNEL][KERNEL];

   logic                  w_accept;
   logic                  w_first;
   logic                  w_last_col;
   logic                  w_last_row;
   logic [DIM_BITS-1:0]   w_w;
   logic [DIM_BITS-1:0]   w_h;
   logic [DATA_WIDTH-1:0] w_tap [KERNEL];

   assign w_accept   = in_valid & ~clear;
   assign w_first    = (r_row == '0) && (r_col == '0);
   // Geometry is taken live on the frame's first pixel, from the latch afterwards
   assign w_w        = w_first ? ((img_width > c_max_w) ? c_max_w : img_width) : r_w;
   assign w_h        = w_first ? img_height : r_h;
   assign w_last_col = (r_col == (w_w - c_one));
   assign w_last_row = (r_row == (w_h - c_one));

   // Tap column: newest pixel at the bottom, oldest line memory at the top
   assign w_tap[KERNEL-1] = in_data;
   for (genvar j = 1; j < KERNEL; j++) begin : g_tap
      assign w_tap[KERNEL-1-j] = r_line[j-1][r_col];
   end

   always_ff @(posedge clk) begin
      if (w_accept && (r_col < c_max_w)) begin
         r_line[0][r_col] <= in_data;
         for (int j = 1; j < KERNEL - 1; j++) begin
            r_line[j][r_col] <= r_line[j-1][r_col];
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_col        <= '0;
         r_row        <= '0;
         r_w          <= '0;
         r_h          <= '0;
         r_win_valid  <= 1'b0;
         r_frame_done <= 1'b0;
         for (int r = 0; r < KERNEL; r++) begin
            for (int c = 0; c < KERNEL; c++) begin
               r_win[r][c] <= '0;
            end
         end
      end else if (clear) begin
         r_col        <= '0;
         r_row        <= '0;
         r_win_valid  <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_win_valid  <= 1'b0;
         r_frame_done <= 1'b0;
         if (in_valid) begin
            if (w_first) begin
               r_w <= w_w;
               r_h <= w_h;
            end
            if (w_last_col) begin
               r_col <= '0;
               r_row <= w_last_row ? '0 : (r_row + c_one);
            end else begin
               r_col <= r_col + c_one;
            end
            r_win_valid  <= (r_row >= c_km1) && (r_col >= c_km1);
            r_frame_done <= w_last_col && w_last_row;
            for (int r = 0; r < KERNEL; r++) begin
               for (int c = 0; c < KERNEL - 1; c++) begin
                  r_win[r][c] <= r_win[r][c+1];
               end
               r_win[r][KERNEL-1] <= w_tap[r];
            end
         end
      end
   end

   assign win_valid  = r_win_valid;
   assign frame_done = r_frame_done;

   for (genvar r = 0; r < KERNEL; r++) begin : g_row
      for (genvar c = 0; c < KERNEL; c++) begin : g_col
         assign win_data[(r*KERNEL+c)*DATA_WIDTH +: DATA_WIDTH] = r_win[r][c];
      end
   end

endmodule
`default_nettype wire

// File: doc/conv_window_buffer.md
# conv_window_buffer

Parametrised K×K sliding-window generator for the convolution datapath. It accepts a raster-order pixel stream with a runtime-programmable image width and height, and holds the previous K-1 rows in circular line memories. For every valid (unpadded) window position it presents a full K×K pixel window to the downstream MAC array. It is the successor to the fixed-width single-line shift-register buffer, generalised in kernel size, maximum width and runtime geometry, and adds valid tracking and frame control.

## Interface
- DATA_WIDTH, 8, pixel width in bits
- KERNEL, 3, window size K (K ≥ 2); K-1 line memories
- MAX_IMG_WIDTH, 224, depth of each line memory
- DIM_BITS, 8, width of the geometry inputs and the internal row/col counters

- clk  in  1  single clock; all state updates on the rising edge
- resetn  in  1  asynchronous, active-low reset
- clear  in  1  synchronous frame restart (abort the current frame)
- img_width  in  DIM_BITS  pixels per row; latched at the first pixel of a frame
- img_height  in  DIM_BITS  rows per frame; latched at the first pixel of a frame
- in_valid  in  1  in_data is accepted this cycle; no backpressure
- in_data  in  DATA_WIDTH  pixel, raster order
- win_valid  out  1  win_data holds a new window (1-cycle pulse per window)
- win_data  out  KERNEL*KERNEL*DATA_WIDTH  window; element r*K+c sits at bits [(r*K+c)*DATA_WIDTH +: DATA_WIDTH]
- frame_done  out  1  pulse coincident with the win_valid of the frame's last pixel

## Operation
- Counters: col runs 0..W-1 and row runs 0..H-1. Both advance only on an accepted pixel. col wraps to 0 and increments row; after (H-1, W-1) both return to 0.
- W and H are latched from img_width/img_height when a pixel is accepted at (0,0).
- W > MAX_IMG_WIDTH is treated as MAX_IMG_WIDTH.
- W < K or H < K is legal, but produces no windows. frame_done still pulses at the last pixel.
- Line memories L[0..K-2], each MAX_IMG_WIDTH deep and addressed by col. On an accepted pixel:
  - Tap column: t[K-1] = in_data and t[K-1-j] = L[j-1][col] for j = 1..K-1 (t[0] is the oldest row).
  - Then write L[0][col] = in_data and L[j][col] = old L[j-1][col].
- Window register W[r][c], r,c in 0..K-1. On an accepted pixel, every row shifts left (W[r][c] = W[r][c+1]) and W[r][K-1] = t[r].
- After the pixel at (row, col), W[r][c] = pixel(row-K+1+r, col-K+1+c). So r=0 is the top (oldest) row and c=0 is the left column.
- win_valid is set the cycle after accepting a pixel with row ≥ K-1 and col ≥ K-1; otherwise it is 0.
- Windows never straddle rows: the col ≥ K-1 gating excludes any window containing stale left-edge columns.
- frame_done is set the cycle after accepting the pixel at (H-1, W-1).
- clear: counters go to 0, and win_valid/frame_done go to 0 next cycle. If clear and in_valid are both high, clear wins and the pixel is dropped. Line memory and window contents are not cleared; they are don't-care because of the row/col gating.

## Timing
- Reset values: win_valid=0, frame_done=0, win_data=0, row=0, col=0, latched W/H=0. Line memory contents are unreset and don't-care.
- Reset asserted mid-frame: outputs drop immediately (asynchronous). The first pixel after release is treated as (0,0).
- Latency: 1 cycle from accepting the completing pixel to win_valid and win_data.
- win_data holds its value until the next accepted pixel.
- Throughput: one pixel per cycle, sustained. Gaps in in_valid stall all state, and win_valid stays 0 during gaps.
- Line memory accesses are a read-before-write to the same address in the same cycle, and must return the old data. Implement as registers or as a read-first RAM with combinational read.
- img_width/img_height changes mid-frame have no effect until the next (0,0).

## Test plan
- **Basic frame.** K=3, W=5, H=4, pixel = row*16+col, continuous in_valid.
  - First win_valid occurs 1 cycle after pixel (2,2) (the 13th accepted pixel).
  - That window's elements 0..8 are 0x00,01,02,10,11,12,20,21,22.
  - Exactly 6 windows are produced. The last is 0x12,13,14,22,23,24,32,33,34, with frame_done high on the same cycle.
- **Gapped input.** Same frame as above, with in_valid randomly deasserted 50% of the time. The window sequence is identical to the basic frame, and win_valid is never high without a preceding accepted pixel.
- **Back-to-back frames with a geometry change.** Frame 1 uses W=5, H=4; frame 2 uses W=4, H=3, with pixel = 0x80+row*16+col.
  - Frame 2 yields 2 windows, and the first is 0x80,81,82,90,91,92,A0,A1,A2.
  - No frame-1 data appears in any frame-2 window.
- **Clear mid-frame.**
  - Assert clear on the cycle with in_valid=1 at pixel (2,1). That pixel is dropped and no window is emitted.
  - A new full frame fed next produces the basic-frame results.
- **Async reset mid-frame.**
  - Drop resetn between clock edges at pixel (3,0). win_valid, frame_done and win_data go to 0 immediately.
  - After release, a full frame produces the basic-frame results.
- **Degenerate geometry.**
  - W=2, H=4: no win_valid, and frame_done pulses once after the 8th pixel.
  - W=MAX_IMG_WIDTH, H=3: exactly MAX_IMG_WIDTH-2 windows.
